mc_control_unit: RTL and testbench

MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

---
 rtl/mc_control_unit_if.sv | 35 +++
 rtl/mc_control_unit.sv | 183 ++++++++++++++++++
 tb/tb_mc_control_unit.sv | 308 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_control_unit_if.sv
// Control-unit signal bundle: instruction/data memory handshakes, ALU flag, datapath controls and status.
interface mc_control_unit_if #(
  parameter int CNT_W = 32
);
  logic [31:0]      instr;
  logic             ihit;
  logic             dhit;
  logic             zero;
  logic             iREN;
  logic             dREN;
  logic             dWEN;
  logic             PCWr;
  logic [1:0]       PCSel;
  logic             RegWr;
  logic [3:0]       ALUCtr;
  logic             ALUSrc;
  logic             MemtoReg;
  logic             ExtOp;
  logic             halt;
  logic             err;
  logic [2:0]       state;
  logic [CNT_W-1:0] retired;

  modport master (
    input  instr, ihit, dhit, zero,
    output iREN, dREN, dWEN, PCWr, PCSel, RegWr, ALUCtr, ALUSrc, MemtoReg, ExtOp,
           halt, err, state, retired
  );

  modport slave (
    output instr, ihit, dhit, zero,
    input  iREN, dREN, dWEN, PCWr, PCSel, RegWr, ALUCtr, ALUSrc, MemtoReg, ExtOp,
           halt, err, state, retired
  );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle MIPS-subset control FSM: ALU op 4 cycles, LW 5, SW 4, branch/J/JR 3 on first-cycle hits.
// Stalls in FETCH/MEM until ihit/dhit, faulting after WAIT_MAX misses; MCU_PERF_CNT_EN enables the retired counter.
module mc_control_unit #(
  parameter int CNT_W    = 32,
  parameter int WAIT_MAX = 15
) (
  input logic               clk,
  input logic               rst,
  mc_control_unit_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH = 3'd0, S_DECODE = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
    S_WB = 3'd4, S_HALTED = 3'd5, S_ERROR = 3'd6
  } state_t;

  typedef enum logic [3:0] {
    ALU_SLL = 4'd0, ALU_SRL = 4'd1, ALU_ADD = 4'd2, ALU_SUB = 4'd3,
    ALU_AND = 4'd4, ALU_OR = 4'd5, ALU_XOR = 4'd6, ALU_NOR = 4'd7,
    ALU_SLT = 4'd8, ALU_SLTU = 4'd9, ALU_LUI = 4'd10
  } aluop_t;

  typedef enum logic [3:0] {
    C_NOP, C_ALU, C_LW, C_SW, C_BEQ, C_BNE, C_J, C_JR, C_JAL, C_HALT
  } iclass_t;

  localparam int              WAIT_W    = $clog2(WAIT_MAX + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  state_t            state_q, state_d;
  logic [11:0]       ir_q;      // only opcode and funct steer control; the datapath keeps the full word
  logic              ir_load;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [5:0]        opcode, funct;
  iclass_t           iclass;
  aluop_t            aluop;
  logic              alu_src, ext_op;

  assign opcode = ir_q[11:6];
  assign funct  = ir_q[5:0];

  always_comb begin
    iclass  = C_NOP;
    aluop   = ALU_SLL;
    alu_src = 1'b0;
    ext_op  = 1'b0;
    case (opcode)
      6'h00: begin
        case (funct)
          6'h20, 6'h21: begin iclass = C_ALU; aluop = ALU_ADD;  end
          6'h22, 6'h23: begin iclass = C_ALU; aluop = ALU_SUB;  end
          6'h24:        begin iclass = C_ALU; aluop = ALU_AND;  end
          6'h25:        begin iclass = C_ALU; aluop = ALU_OR;   end
          6'h26:        begin iclass = C_ALU; aluop = ALU_XOR;  end
          6'h27:        begin iclass = C_ALU; aluop = ALU_NOR;  end
          6'h2A:        begin iclass = C_ALU; aluop = ALU_SLT;  end
          6'h2B:        begin iclass = C_ALU; aluop = ALU_SLTU; end
          6'h00:        begin iclass = C_ALU; aluop = ALU_SLL; alu_src = 1'b1; end
          6'h02:        begin iclass = C_ALU; aluop = ALU_SRL; alu_src = 1'b1; end
          6'h08:        iclass = C_JR;
          default:      iclass = C_NOP;
        endcase
      end
      6'h08, 6'h09: begin iclass = C_ALU; aluop = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; end
      6'h0A:        begin iclass = C_ALU; aluop = ALU_SLT;  alu_src = 1'b1; ext_op = 1'b1; end
      6'h0B:        begin iclass = C_ALU; aluop = ALU_SLTU; alu_src = 1'b1; ext_op = 1'b1; end
      6'h0C:        begin iclass = C_ALU; aluop = ALU_AND;  alu_src = 1'b1; end
      6'h0D:        begin iclass = C_ALU; aluop = ALU_OR;   alu_src = 1'b1; end
      6'h0E:        begin iclass = C_ALU; aluop = ALU_XOR;  alu_src = 1'b1; end
      6'h0F:        begin iclass = C_ALU; aluop = ALU_LUI;  alu_src = 1'b1; end
      6'h23:        begin iclass = C_LW;  aluop = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; end
      6'h2B:        begin iclass = C_SW;  aluop = ALU_ADD;  alu_src = 1'b1; ext_op = 1'b1; end
      6'h04:        begin iclass = C_BEQ; aluop = ALU_SUB;  ext_op = 1'b1; end
      6'h05:        begin iclass = C_BNE; aluop = ALU_SUB;  ext_op = 1'b1; end
      6'h02:        iclass = C_J;
      6'h03:        iclass = C_JAL;
      6'h3F:        iclass = C_HALT;
      default:      iclass = C_NOP;
    endcase
  end

  assign bus.ALUCtr = aluop;
  assign bus.ALUSrc = alu_src;
  assign bus.ExtOp  = ext_op;

  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    ir_load      = 1'b0;
    bus.iREN     = 1'b0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.PCWr     = 1'b0;
    bus.PCSel    = 2'b00;
    bus.RegWr    = 1'b0;
    bus.MemtoReg = 1'b0;
    case (state_q)
      S_FETCH: begin
        bus.iREN = 1'b1;
        // a hit in the last allowed cycle still wins over the timeout
        if (bus.ihit) begin
          ir_load  = 1'b1;
          bus.PCWr = 1'b1;
          state_d  = S_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        case (iclass)
          C_BEQ:  begin bus.PCWr = bus.zero;  bus.PCSel = {1'b0, bus.zero};  state_d = S_FETCH; end
          C_BNE:  begin bus.PCWr = !bus.zero; bus.PCSel = {1'b0, !bus.zero}; state_d = S_FETCH; end
          C_J:    begin bus.PCWr = 1'b1; bus.PCSel = 2'b10; state_d = S_FETCH; end
          C_JR:   begin bus.PCWr = 1'b1; bus.PCSel = 2'b11; state_d = S_FETCH; end
          C_LW, C_SW: state_d = S_MEM;
          C_HALT: state_d = S_HALTED;
          C_ALU, C_JAL: state_d = S_WB;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        bus.dREN = (iclass == C_LW);
        bus.dWEN = (iclass == C_SW);
        if (bus.dhit) begin
          state_d = (iclass == C_LW) ? S_WB : S_FETCH;
        end else if (wait_q == WAIT_LAST) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        bus.RegWr    = 1'b1;
        bus.MemtoReg = (iclass == C_LW);
        if (iclass == C_JAL) begin
          bus.PCWr  = 1'b1;
          bus.PCSel = 2'b10;
        end
        state_d = S_FETCH;
      end
      S_HALTED, S_ERROR: state_d = state_q;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (ir_load) ir_q <= {bus.instr[31:26], bus.instr[5:0]};
    end
  end

  assign bus.state = state_q;
  assign bus.halt  = (state_q == S_HALTED);
  assign bus.err   = (state_q == S_ERROR);

`ifdef MCU_PERF_CNT_EN
  logic             retire;
  logic [CNT_W-1:0] retired_q;

  // the final hop of an instruction back to FETCH (or into HALTED) is its retirement
  assign retire = (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) &&
                  (state_d == S_FETCH || state_d == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst)         retired_q <= '0;
    else if (retire) retired_q <= retired_q + 1'b1;
  end

  assign bus.retired = retired_q;
`else
  assign bus.retired = '0;
`endif

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instruction table plus randomized instruction streams against a trace-level model.
module tb_mc_control_unit;
  localparam int CNT_W    = 4;
  localparam int WAIT_MAX = 15;

  localparam logic [3:0] A_SLL = 4'd0, A_SRL = 4'd1, A_ADD = 4'd2, A_SUB = 4'd3,
                         A_AND = 4'd4, A_OR = 4'd5, A_XOR = 4'd6, A_NOR = 4'd7,
                         A_SLT = 4'd8, A_SLTU = 4'd9, A_LUI = 4'd10;

  typedef enum int {K_ALU, K_LW, K_SW, K_BEQ, K_BNE, K_J, K_JR, K_JAL, K_HALT, K_NOP} kind_t;
  typedef struct {
    logic [31:0] instr;
    kind_t       k;
    logic        z;
    logic        chk_ctr;
    logic [3:0]  ctr;
    logic        src;
    logic        ext;
  } vec_t;
  typedef struct {
    logic        ih;
    logic        dh;
    logic        z;
    logic [31:0] ins;
    logic [2:0]  st;
    logic [7:0]  e;
    logic        ret;
    logic        alu;
  } cyc_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mc_control_unit_if #(.CNT_W(CNT_W)) bus();
  mc_control_unit #(.CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (.clk(clk), .rst(rst), .bus(bus));

  int    errors = 0;
  int    checks = 0;
  int    n_ret  = 0;
  vec_t  tab[$];
  vec_t  cur;
  cyc_t  q[$];
  string tag = "init";

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got running want finished");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%s]: got %0h want %0h", name, tag, act, exp);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(1, 0));
  endfunction

  function automatic logic [7:0] mk_en(logic i, logic d, logic w, logic pw, logic [1:0] ps, logic rw, logic mr);
    return {i, d, w, pw, ps, rw, mr};
  endfunction

  function automatic logic [CNT_W-1:0] exp_ret();
`ifdef MCU_PERF_CNT_EN
    return CNT_W'(n_ret);
`else
    return '0;
`endif
  endfunction

  function automatic vec_t mkvec(logic [31:0] instr, kind_t k, logic z, logic chk, logic [3:0] ctr, logic src, logic ext);
    vec_t v;
    v.instr = instr; v.k = k; v.z = z; v.chk_ctr = chk; v.ctr = ctr; v.src = src; v.ext = ext;
    return v;
  endfunction

  function automatic logic [31:0] rtype(logic [5:0] f);
    return {6'h00, 20'h0, f};
  endfunction

  function automatic logic [31:0] itype(logic [5:0] op);
    return {op, 26'h0};
  endfunction

  task automatic add_cyc(input logic ih, input logic dh, input logic z, input logic [31:0] ins,
                         input logic [2:0] st, input logic [7:0] e, input logic ret, input logic alu);
    cyc_t c;
    c.ih = ih; c.dh = dh; c.z = z; c.ins = ins; c.st = st; c.e = e; c.ret = ret; c.alu = alu;
    q.push_back(c);
  endtask

  task automatic err_tail();
    repeat (3) add_cyc(rb(), rb(), rb(), $urandom(), 3'd6, 8'h00, 1'b0, 1'b0);
  endtask

  // Expected per-cycle trace of one instruction, built from its phases and the stall lengths.
  task automatic gen(input vec_t v, input int iw, input int dw, output logic stuck);
    logic lw = (v.k == K_LW);
    logic sw = (v.k == K_SW);
    logic jal = (v.k == K_JAL);
    cur   = v;
    stuck = 1'b0;
    for (int i = 0; i < iw && i < WAIT_MAX; i++)
      add_cyc(1'b0, rb(), rb(), $urandom(), 3'd0, mk_en(1, 0, 0, 0, 2'b00, 0, 0), 1'b0, 1'b0);
    if (iw >= WAIT_MAX) begin
      err_tail();
      stuck = 1'b1;
      return;
    end
    add_cyc(1'b1, rb(), rb(), v.instr, 3'd0, mk_en(1, 0, 0, 1, 2'b00, 0, 0), 1'b0, 1'b0);
    add_cyc(rb(), rb(), rb(), $urandom(), 3'd1, 8'h00, 1'b0, 1'b1);
    case (v.k)
      K_BEQ:  add_cyc(rb(), rb(), v.z, $urandom(), 3'd2, mk_en(0, 0, 0, v.z, {1'b0, v.z}, 0, 0), 1'b1, 1'b0);
      K_BNE:  add_cyc(rb(), rb(), v.z, $urandom(), 3'd2, mk_en(0, 0, 0, !v.z, {1'b0, !v.z}, 0, 0), 1'b1, 1'b0);
      K_J:    add_cyc(rb(), rb(), rb(), $urandom(), 3'd2, mk_en(0, 0, 0, 1, 2'b10, 0, 0), 1'b1, 1'b0);
      K_JR:   add_cyc(rb(), rb(), rb(), $urandom(), 3'd2, mk_en(0, 0, 0, 1, 2'b11, 0, 0), 1'b1, 1'b0);
      K_NOP:  add_cyc(rb(), rb(), rb(), $urandom(), 3'd2, 8'h00, 1'b1, 1'b0);
      K_HALT: begin
        add_cyc(rb(), rb(), rb(), $urandom(), 3'd2, 8'h00, 1'b1, 1'b0);
        repeat (3) add_cyc(rb(), rb(), rb(), $urandom(), 3'd5, 8'h00, 1'b0, 1'b0);
        stuck = 1'b1;
      end
      default: add_cyc(rb(), rb(), rb(), $urandom(), 3'd2, 8'h00, 1'b0, 1'b0);
    endcase
    if (lw || sw) begin
      for (int i = 0; i < dw && i < WAIT_MAX; i++)
        add_cyc(rb(), 1'b0, rb(), $urandom(), 3'd3, mk_en(0, lw, sw, 0, 2'b00, 0, 0), 1'b0, 1'b0);
      if (dw >= WAIT_MAX) begin
        err_tail();
        stuck = 1'b1;
        return;
      end
      add_cyc(rb(), 1'b1, rb(), $urandom(), 3'd3, mk_en(0, lw, sw, 0, 2'b00, 0, 0), sw, 1'b0);
    end
    if (v.k == K_ALU || lw || jal)
      add_cyc(rb(), rb(), rb(), $urandom(), 3'd4, mk_en(0, 0, 0, jal, jal ? 2'b10 : 2'b00, 1, lw), 1'b1, 1'b0);
  endtask

  task automatic run_q(input int max_cyc);
    cyc_t c;
    int   n = 0;
    while (q.size() > 0 && n < max_cyc) begin
      c = q.pop_front();
      n++;
      bus.ihit  = c.ih;
      bus.dhit  = c.dh;
      bus.zero  = c.z;
      bus.instr = c.ins;
      #1;
      check("ctrl", 64'({bus.state, bus.halt, bus.err, bus.iREN, bus.dREN, bus.dWEN, bus.PCWr,
                         bus.PCSel, bus.RegWr, bus.MemtoReg}),
                    64'({c.st, c.st == 3'd5, c.st == 3'd6, c.e}));
      check("retired", 64'(bus.retired), 64'(exp_ret()));
      if (c.alu) begin
        check("alu_src_ext", 64'({bus.ALUSrc, bus.ExtOp}), 64'({cur.src, cur.ext}));
        if (cur.chk_ctr) check("alu_ctr", 64'(bus.ALUCtr), 64'(cur.ctr));
      end
      @(posedge clk);
      #1;
      if (c.ret) n_ret++;
    end
  endtask

  task automatic do_reset(input logic dh);
    rst       = 1'b1;
    bus.ihit  = rb();
    bus.dhit  = dh;
    bus.zero  = rb();
    bus.instr = $urandom();
    @(posedge clk);
    #1;
    rst   = 1'b0;
    n_ret = 0;
  endtask

  task automatic chk_reset();
    bus.ihit = 1'b0;
    #1;
    check("rst_ctrl", 64'({bus.state, bus.halt, bus.err, bus.iREN, bus.dREN, bus.dWEN, bus.PCWr,
                           bus.PCSel, bus.RegWr}), 64'({3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0}));
    check("rst_aluctr", 64'(bus.ALUCtr), 64'(A_SLL));
    check("rst_retired", 64'(bus.retired), 64'd0);
  endtask

  initial begin
    vec_t v, v_addu, v_lw, v_sw, v_halt, v_nop;
    logic stuck;
    logic [CNT_W-1:0] wrap_exp;
    int iw, dw;

    v_addu = mkvec(rtype(6'h21), K_ALU, 1'b0, 1'b1, A_ADD, 1'b0, 1'b0);
    v_lw   = mkvec(itype(6'h23), K_LW,  1'b0, 1'b1, A_ADD, 1'b1, 1'b1);
    v_sw   = mkvec(itype(6'h2B), K_SW,  1'b0, 1'b1, A_ADD, 1'b1, 1'b1);
    v_halt = mkvec(itype(6'h3F), K_HALT, 1'b0, 1'b0, A_SLL, 1'b0, 1'b0);
    v_nop  = mkvec(32'h0, K_ALU, 1'b0, 1'b1, A_SLL, 1'b1, 1'b0);
    tab.push_back(mkvec(rtype(6'h20), K_ALU, 0, 1, A_ADD,  0, 0));
    tab.push_back(v_addu);
    tab.push_back(mkvec(rtype(6'h22), K_ALU, 0, 1, A_SUB,  0, 0));
    tab.push_back(mkvec(rtype(6'h23), K_ALU, 0, 1, A_SUB,  0, 0));
    tab.push_back(mkvec(rtype(6'h24), K_ALU, 0, 1, A_AND,  0, 0));
    tab.push_back(mkvec(rtype(6'h25), K_ALU, 0, 1, A_OR,   0, 0));
    tab.push_back(mkvec(rtype(6'h26), K_ALU, 0, 1, A_XOR,  0, 0));
    tab.push_back(mkvec(rtype(6'h27), K_ALU, 0, 1, A_NOR,  0, 0));
    tab.push_back(mkvec(rtype(6'h2A), K_ALU, 0, 1, A_SLT,  0, 0));
    tab.push_back(mkvec(rtype(6'h2B), K_ALU, 0, 1, A_SLTU, 0, 0));
    tab.push_back(v_nop);
    tab.push_back(mkvec(rtype(6'h02), K_ALU, 0, 1, A_SRL,  1, 0));
    tab.push_back(mkvec(rtype(6'h08), K_JR,  0, 0, A_SLL,  0, 0));
    tab.push_back(mkvec(rtype(6'h3F), K_NOP, 0, 0, A_SLL,  0, 0));
    tab.push_back(mkvec(itype(6'h08), K_ALU, 0, 1, A_ADD,  1, 1));
    tab.push_back(mkvec(itype(6'h09), K_ALU, 0, 1, A_ADD,  1, 1));
    tab.push_back(mkvec(itype(6'h0A), K_ALU, 0, 1, A_SLT,  1, 1));
    tab.push_back(mkvec(itype(6'h0B), K_ALU, 0, 1, A_SLTU, 1, 1));
    tab.push_back(mkvec(itype(6'h0C), K_ALU, 0, 1, A_AND,  1, 0));
    tab.push_back(mkvec(itype(6'h0D), K_ALU, 0, 1, A_OR,   1, 0));
    tab.push_back(mkvec(itype(6'h0E), K_ALU, 0, 1, A_XOR,  1, 0));
    tab.push_back(mkvec(itype(6'h0F), K_ALU, 0, 1, A_LUI,  1, 0));
    tab.push_back(v_lw);
    tab.push_back(v_sw);
    tab.push_back(mkvec(itype(6'h04), K_BEQ, 1, 0, A_SLL,  0, 1));
    tab.push_back(mkvec(itype(6'h05), K_BNE, 1, 0, A_SLL,  0, 1));
    tab.push_back(mkvec(itype(6'h04), K_BEQ, 0, 0, A_SLL,  0, 1));
    tab.push_back(mkvec(itype(6'h05), K_BNE, 0, 0, A_SLL,  0, 1));
    tab.push_back(mkvec(itype(6'h02), K_J,   0, 0, A_SLL,  0, 0));
    tab.push_back(mkvec(itype(6'h03), K_JAL, 0, 0, A_SLL,  0, 0));
    tab.push_back(mkvec(itype(6'h3E), K_NOP, 0, 0, A_SLL,  0, 0));

    tag = "reset";
    do_reset(1'b0);
    chk_reset();

    foreach (tab[i]) begin
      tag = $sformatf("vec%0d", i);
      gen(tab[i], 0, 0, stuck);
      run_q(1000);
    end

    tag = "lw_dhit_late";
    gen(v_lw, 0, 3, stuck);
    run_q(1000);

    tag = "fetch_hit_last";
    gen(v_addu, WAIT_MAX - 1, 0, stuck);
    run_q(1000);
    tag = "mem_hit_last";
    gen(v_lw, 1, WAIT_MAX - 1, stuck);
    run_q(1000);
    tag = "fetch_timeout";
    gen(v_addu, WAIT_MAX, 0, stuck);
    run_q(1000);
    do_reset(1'b0);
    chk_reset();
    tag = "mem_timeout";
    gen(v_sw, 2, WAIT_MAX, stuck);
    run_q(1000);
    do_reset(1'b0);
    chk_reset();

    tag = "halt_then_rst";
    gen(v_addu, 0, 0, stuck);
    run_q(1000);
    gen(v_halt, 1, 0, stuck);
    run_q(1000);
    do_reset(1'b0);
    chk_reset();

    tag = "rst_mid_mem";
    gen(v_lw, 0, 8, stuck);
    run_q(6);
    q.delete();
    do_reset(1'b1);
    chk_reset();

    tag = "nop_wrap";
    do_reset(1'b0);
    repeat (17) begin
      gen(v_nop, 0, 0, stuck);
      run_q(1000);
    end
`ifdef MCU_PERF_CNT_EN
    wrap_exp = CNT_W'(1);
`else
    wrap_exp = '0;
`endif
    check("nop_wrap_retired", 64'(bus.retired), 64'(wrap_exp));

    for (int n = 0; n < 200; n++) begin
      tag = $sformatf("rand%0d", n);
      v = ($urandom_range(24, 0) == 0) ? v_halt : tab[$urandom_range(tab.size() - 1, 0)];
      v.instr[25:6] = 20'($urandom());
      if (v.instr[31:26] != 6'h00) v.instr[5:0] = 6'($urandom());
      v.z = rb();
      iw = ($urandom_range(19, 0) == 0) ? int'($urandom_range(16, 13)) : int'($urandom_range(3, 0));
      dw = ($urandom_range(19, 0) == 0) ? int'($urandom_range(16, 13)) : int'($urandom_range(3, 0));
      gen(v, iw, dw, stuck);
      run_q(1000);
      if (stuck) do_reset(rb());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
